time_set_controller: RTL and testbench

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

---
 rtl/time_set_controller.sv | 130 +++++++++++++
 tb/tb_time_set_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// Purpose : HH:MM:SS timekeeper. A mode button steps RUN -> SET_HOUR -> SET_MIN -> RUN.
//           In the set states btn_inc edits the selected field, and the block drops back
//           to RUN after TIMEOUT idle ticks.
// Latency : every output is registered and changes one clk after the input pulse.
//           A timeout takes effect one clk after the tick that reaches TIMEOUT.
// Backpr. : none. Inputs are one-clk pulses and each pulse is acted on in its own cycle.
// Ports   : clk, rst (sync, active-high), tick_1hz, btn_mode, btn_inc ->
//           seconds[5:0], minutes[5:0], hours[4:0], set, mode[1:0], blink
module time_set_controller #(
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       set,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int IW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [5:0]    sec_nxt, min_nxt;
  logic [4:0]    hr_nxt;
  logic          blink_nxt;
  logic [IW-1:0] idle, idle_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      seconds <= '0;
      minutes <= '0;
      hours   <= '0;
      set     <= 1'b0;
      blink   <= 1'b0;
      idle    <= '0;
    end else begin
      state   <= state_nxt;
      seconds <= sec_nxt;
      minutes <= min_nxt;
      hours   <= hr_nxt;
      set     <= (state_nxt != RUN);
      blink   <= blink_nxt;
      idle    <= idle_nxt;
    end
  end

  // The state register is the mode output.
  assign mode = state;

  always_comb begin
    state_nxt = state;
    sec_nxt   = seconds;
    min_nxt   = minutes;
    hr_nxt    = hours;
    blink_nxt = blink;
    idle_nxt  = idle;

    unique case (state)
      RUN: begin
        idle_nxt  = '0;
        blink_nxt = 1'b0;
        if (btn_mode) begin
          state_nxt = SET_HOUR;
          sec_nxt   = '0;
          blink_nxt = 1'b1;
        end else if (tick_1hz) begin
          // Seconds, minutes and hours all carry in the same cycle.
          if (seconds == 6'd59) begin
            sec_nxt = '0;
            if (minutes == 6'd59) begin
              min_nxt = '0;
              hr_nxt  = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
            end else begin
              min_nxt = minutes + 6'd1;
            end
          end else begin
            sec_nxt = seconds + 6'd1;
          end
        end
      end

      SET_HOUR, SET_MIN: begin
        sec_nxt = '0;
        // A button always wins. It clears the idle count even when it lands on
        // the tick that would have reached TIMEOUT.
        if (btn_mode) begin
          idle_nxt = '0;
          if (state == SET_HOUR) begin
            state_nxt = SET_MIN;
            blink_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
            blink_nxt = 1'b0;
          end
        end else if (btn_inc) begin
          idle_nxt = '0;
          if (tick_1hz) blink_nxt = ~blink;
          if (state == SET_HOUR) hr_nxt  = (hours == 5'd23)   ? 5'd0 : hours + 5'd1;
          else                   min_nxt = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
        end else if (idle == IW'(TIMEOUT)) begin
          state_nxt = RUN;
          idle_nxt  = '0;
          blink_nxt = 1'b0;
        end else if (tick_1hz) begin
          idle_nxt  = idle + IW'(1);
          blink_nxt = ~blink;
        end
      end

      default: begin
        state_nxt = RUN;
        blink_nxt = 1'b0;
        idle_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed scoreboard bench for time_set_controller. The stimulus pushes hand-computed
// expected outputs into a queue. A negedge monitor pops and compares them.
module tb_time_set_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic       set;
  logic [1:0] mode;
  logic       blink;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [20:0] val;   // {sec, min, hr, set, mode, blink}
  } exp_t;

  exp_t exp_q[$];

  time_set_controller #(.TIMEOUT(30)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .set(set), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable at the negedge, so each queued expectation is
  // compared against them there.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [20:0] got;
      e   = exp_q.pop_front();
      got = {seconds, minutes, hours, set, mode, blink};
      total++;
      if (got !== e.val) begin
        bad++;
        $display("FAIL %s: got s=%0d m=%0d h=%0d set=%0b mode=%0d blink=%0b, need s=%0d m=%0d h=%0d set=%0b mode=%0d blink=%0b",
                 e.name, seconds, minutes, hours, set, mode, blink,
                 e.val[20:15], e.val[14:9], e.val[8:4], e.val[3], e.val[2:1], e.val[0]);
      end
    end
  end

  // Drives one cycle of inputs, then releases them just after the posedge.
  task automatic step(input logic t, input logic m, input logic i);
    tick_1hz = t; btn_mode = m; btn_inc = i;
    @(posedge clk); #1;
    tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic repeat_step(input int n, input logic t, input logic m, input logic i);
    for (int k = 0; k < n; k++) step(t, m, i);
  endtask

  task automatic exp_push(input string n, input logic [5:0] s, input logic [5:0] mi,
                          input logic [4:0] h, input logic st, input logic [1:0] md,
                          input logic b);
    exp_t e;
    e.name = n;
    e.val  = {s, mi, h, st, md, b};
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset, held with a coincident tick and buttons.
    @(posedge clk); #1;
    step(1, 1, 1);
    exp_push("reset", 0, 0, 0, 0, 2'd0, 0);
    rst = 1'b0;

    // 61 ticks -> 00:01:01. btn_inc in RUN is ignored.
    repeat_step(61, 1, 0, 0);
    exp_push("tick61", 1, 1, 0, 0, 2'd0, 0);
    step(0, 0, 1);
    exp_push("inc_in_run", 1, 1, 0, 0, 2'd0, 0);

    // Preload 10:20:35.
    step(0, 1, 0);
    exp_push("enter_set_hour", 0, 1, 0, 1, 2'd1, 1);
    repeat_step(10, 0, 0, 1);
    step(0, 1, 0);
    repeat_step(19, 0, 0, 1);
    step(0, 1, 0);
    exp_push("preload_run", 0, 20, 10, 0, 2'd0, 0);
    repeat_step(35, 1, 0, 0);
    exp_push("at_10_20_35", 35, 20, 10, 0, 2'd0, 0);

    // Edit to 01:05:00.
    step(0, 1, 0);
    exp_push("set_hour_sec0", 0, 20, 10, 1, 2'd1, 1);
    repeat_step(15, 0, 0, 1);
    exp_push("hour_wrap_inc15", 0, 20, 1, 1, 2'd1, 1);
    step(0, 1, 0);
    exp_push("enter_set_min", 0, 20, 1, 1, 2'd2, 1);
    repeat_step(45, 0, 0, 1);
    exp_push("min_wrap_inc45", 0, 5, 1, 1, 2'd2, 1);
    step(0, 1, 0);
    exp_push("back_to_run", 0, 5, 1, 0, 2'd0, 0);
    step(1, 0, 0);
    exp_push("first_tick_after_set", 1, 5, 1, 0, 2'd0, 0);

    // Preload 23:59:59, then a tick rolls over the full day.
    step(0, 1, 0);
    repeat_step(22, 0, 0, 1);
    step(0, 1, 0);
    repeat_step(54, 0, 0, 1);
    step(0, 1, 0);
    exp_push("preload_23_59", 0, 59, 23, 0, 2'd0, 0);
    repeat_step(59, 1, 0, 0);
    exp_push("at_23_59_59", 59, 59, 23, 0, 2'd0, 0);
    step(1, 0, 0);
    exp_push("day_rollover", 0, 0, 0, 0, 2'd0, 0);
    step(1, 0, 0);
    exp_push("after_rollover", 1, 0, 0, 0, 2'd0, 0);

    // Timeout in SET_MIN.
    step(0, 1, 0);
    step(0, 1, 0);
    exp_push("set_min_entry", 0, 0, 0, 1, 2'd2, 1);
    repeat_step(29, 1, 0, 0);
    exp_push("tick29_still_set", 0, 0, 0, 1, 2'd2, 0);
    step(1, 0, 0);
    exp_push("tick30_edge", 0, 0, 0, 1, 2'd2, 1);
    step(0, 0, 0);
    exp_push("timeout_to_run", 0, 0, 0, 0, 2'd0, 0);
    step(1, 0, 0);
    exp_push("tick_after_timeout", 1, 0, 0, 0, 2'd0, 0);

    // Coincident buttons.
    step(0, 1, 0);
    repeat_step(2, 0, 0, 1);
    exp_push("hours_2", 0, 0, 2, 1, 2'd1, 1);
    step(0, 1, 1);
    exp_push("mode_and_inc", 0, 0, 2, 1, 2'd2, 1);
    repeat_step(29, 1, 0, 0);
    step(1, 0, 1);
    exp_push("inc_on_tick30", 0, 1, 2, 1, 2'd2, 1);
    step(0, 0, 0);
    exp_push("no_timeout", 0, 1, 2, 1, 2'd2, 1);
    repeat_step(29, 1, 0, 0);
    exp_push("idle_restarted", 0, 1, 2, 1, 2'd2, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    exp_push("late_timeout", 0, 1, 2, 0, 2'd0, 0);

    // Reset from SET_HOUR at hours = 7 with a coincident tick.
    step(0, 1, 0);
    repeat_step(5, 0, 0, 1);
    exp_push("hours_7", 0, 1, 7, 1, 2'd1, 1);
    rst = 1'b1;
    step(1, 0, 0);
    rst = 1'b0;
    exp_push("reset_in_set", 0, 0, 0, 0, 2'd0, 0);
    step(1, 0, 0);
    exp_push("tick_after_reset", 1, 0, 0, 0, 2'd0, 0);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
